// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: control FSM for a multicycle MIPS datapath that shares one ALU and one
// memory between instruction fetch and data access. It decodes opcode/funct, drives every
// datapath enable and mux select each cycle, stalls on the memory handshake, and counts
// retired instructions.
//
// Parameters
//   MEM_WAIT_EN  1: memory states wait for mem_ready; 0: mem_ready is ignored (always ready)
//   RET_W        width of the retired-instruction counter (wraps to 0)
//
// Ports
//   clk, reset             clock; asynchronous active-high reset (FSM->FETCH, retired->0)
//   opcode, funct          IR[31:26], IR[5:0]
//   alu_zero, mem_ready    ALU zero flag; memory access completes this cycle
//   pc_en .. alu_control   datapath enables and mux selects
//   illegal_op             one-cycle flag when an unsupported opcode/funct is decoded
//   retired                retired-instruction count
//   state                  current state encoding (debug)
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_EN = 1,
    parameter int unsigned RET_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_control,
    output logic             illegal_op,
    output logic [RET_W-1:0] retired,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    state_e           state_q, state_d;
    logic [RET_W-1:0] retired_q;
    logic             retire;
    logic             ready;

    assign ready   = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign retired = retired_q;
    assign state   = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + RET_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_control = AluAdd;
        illegal_op  = 1'b0;

        unique case (state_q)
            StFetch: begin
                // PC+4 is computed every fetch cycle but only committed once memory responds
                alu_src_b = 2'b01;
                if (ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Speculatively compute the branch target into ALUOut
                alu_src_b = 2'b11;
                case (opcode)
                    OpRtype:    state_d = StExec;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord = 1'b1;
                if (ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                // Strobe stays high for every stall cycle until memory accepts the write
                iord      = 1'b1;
                mem_write = 1'b1;
                if (ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExec: begin
                alu_src_a = 1'b1;
                state_d   = StAluWb;
                case (funct)
                    6'b100000: alu_control = AluAdd;
                    6'b100010: alu_control = AluSub;
                    6'b100100: alu_control = AluAnd;
                    6'b100101: alu_control = AluOr;
                    6'b101010: alu_control = AluSlt;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StFetch;
                    end
                endcase
            end
            StAluWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a   = 1'b1;
                alu_control = AluSub;
                pc_src      = 2'b01;
                pc_en       = alu_zero;
                retire      = 1'b1;
                state_d     = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // While reset is held the FSM sits in FETCH; suppress every write strobe
        if (reset) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl. The driver applies one cycle of inputs and pushes the
// hand-computed expected state/controls/retired count; the monitor pops and compares on the
// falling edge. A second instance (MEM_WAIT_EN=0, RET_W=4, mem_ready tied low) covers counter wrap
// and the no-stall mode.
module tb_mips_multicycle_ctrl;

    // {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
    //  alu_src_b[1:0], pc_src[1:0], alu_control[2:0], illegal_op}
    typedef logic [15:0] ctl_t;

    typedef struct packed {
        logic [63:0] nm;
        logic [3:0]  st;
        ctl_t        ctl;
        logic [31:0] ret;
        logic        chk1;
        logic [3:0]  ret1;
    } exp_t;

    localparam ctl_t C_FW   = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0};
    localparam ctl_t C_FR   = {8'b1001_0000, 2'b01, 2'b00, 3'b010, 1'b0};
    localparam ctl_t C_DEC  = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0};
    localparam ctl_t C_DECI = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1};
    localparam ctl_t C_MADR = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
    localparam ctl_t C_MRD  = {8'b0100_0000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam ctl_t C_MWB  = {8'b0000_0110, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam ctl_t C_MWR  = {8'b0110_0000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam ctl_t C_EXI  = {8'b0000_0001, 2'b00, 2'b00, 3'b010, 1'b1};
    localparam ctl_t C_AWB  = {8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam ctl_t C_BRT  = {8'b1000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
    localparam ctl_t C_BRN  = {8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
    localparam ctl_t C_AIWB = {8'b0000_0010, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam ctl_t C_JMP  = {8'b1000_0000, 2'b00, 2'b10, 3'b010, 1'b0};

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_ready1;

    logic        pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_control;
    logic        illegal_op;
    logic [31:0] retired;
    logic [3:0]  state;

    logic        pc_en1, iord1, mem_write1, ir_write1, reg_dst1, mem_to_reg1, reg_write1;
    logic        alu_src_a1;
    logic [1:0]  alu_src_b1, pc_src1;
    logic [2:0]  alu_control1;
    logic        illegal_op1;
    logic [3:0]  retired1;
    logic [3:0]  state1;

    ctl_t act0, act1;
    assign act0 = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                   alu_src_b, pc_src, alu_control, illegal_op};
    assign act1 = {pc_en1, iord1, mem_write1, ir_write1, reg_dst1, mem_to_reg1, reg_write1,
                   alu_src_a1, alu_src_b1, pc_src1, alu_control1, illegal_op1};

    mips_multicycle_ctrl #(
        .MEM_WAIT_EN(1),
        .RET_W      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_control(alu_control),
        .illegal_op (illegal_op),
        .retired    (retired),
        .state      (state)
    );

    mips_multicycle_ctrl #(
        .MEM_WAIT_EN(0),
        .RET_W      (4)
    ) dut_nw (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready1),
        .pc_en      (pc_en1),
        .iord       (iord1),
        .mem_write  (mem_write1),
        .ir_write   (ir_write1),
        .reg_dst    (reg_dst1),
        .mem_to_reg (mem_to_reg1),
        .reg_write  (reg_write1),
        .alu_src_a  (alu_src_a1),
        .alu_src_b  (alu_src_b1),
        .pc_src     (pc_src1),
        .alu_control(alu_control1),
        .illegal_op (illegal_op1),
        .retired    (retired1),
        .state      (state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] er;
    logic [3:0]  er1;
    logic        chk1;

    // Monitor: one expected record per cycle, compared on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({state, act0, retired} !== {e.st, e.ctl, e.ret}) begin
                errors++;
                $display("FAIL %s: got st=%0d ctl=%b ret=%0d, want st=%0d ctl=%b ret=%0d",
                         e.nm, state, act0, retired, e.st, e.ctl, e.ret);
            end
            if (e.chk1) begin
                checks++;
                if ({state1, act1, retired1} !== {e.st, e.ctl, e.ret1}) begin
                    errors++;
                    $display("FAIL %s/nowait: got st=%0d ctl=%b ret=%0d, want st=%0d ctl=%b ret=%0d",
                             e.nm, state1, act1, retired1, e.st, e.ctl, e.ret1);
                end
            end
        end
    end

    task automatic step(input logic [63:0] nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic az, input logic mr, input logic rs,
                        input logic [3:0] st, input ctl_t c);
        exp_t e;
        @(posedge clk);
        #1;
        opcode    = op;
        funct     = fn;
        alu_zero  = az;
        mem_ready = mr;
        reset     = rs;
        if (rs) begin
            er  = '0;
            er1 = '0;
        end
        e.nm   = nm;
        e.st   = st;
        e.ctl  = c;
        e.ret  = er;
        e.chk1 = chk1;
        e.ret1 = er1;
        q.push_back(e);
    endtask

    task automatic retire_one();
        er  = er + 32'd1;
        er1 = er1 + 4'd1;
    endtask

    task automatic instr_r(input logic [63:0] nm, input logic [5:0] fn, input logic [2:0] alu);
        step(nm, 6'b000000, fn, 1'b0, 1'b1, 1'b0, 4'd0, C_FR);
        step(nm, 6'b000000, fn, 1'b0, 1'b1, 1'b0, 4'd1, C_DEC);
        step(nm, 6'b000000, fn, 1'b0, 1'b1, 1'b0, 4'd6, {8'b0000_0001, 4'b0000, alu, 1'b0});
        step(nm, 6'b000000, fn, 1'b0, 1'b1, 1'b0, 4'd7, C_AWB);
        retire_one();
    endtask

    task automatic instr_beq(input logic [63:0] nm, input logic az, input ctl_t cbr);
        step(nm, 6'b000100, 6'd0, az, 1'b1, 1'b0, 4'd0, C_FR);
        step(nm, 6'b000100, 6'd0, az, 1'b1, 1'b0, 4'd1, C_DEC);
        step(nm, 6'b000100, 6'd0, az, 1'b1, 1'b0, 4'd8, cbr);
        retire_one();
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = '0;
        funct     = '0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        mem_ready1 = 1'b0;
        chk1      = 1'b0;
        er        = '0;
        er1       = '0;

        // Reset held with mem_ready high: FETCH defaults, no strobes
        step("RST", 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 4'd0, C_FW);
        step("RST", 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 4'd0, C_FW);

        instr_r("ADD", 6'b100000, 3'b010);
        instr_r("SUB", 6'b100010, 3'b110);
        instr_r("AND", 6'b100100, 3'b000);
        instr_r("OR",  6'b100101, 3'b001);
        instr_r("SLT", 6'b101010, 3'b111);

        // lw with two stall cycles in MEMRD: 7 cycles total
        step("LW", 6'b100011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, C_FR);
        step("LW", 6'b100011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, C_DEC);
        step("LW", 6'b100011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd2, C_MADR);
        step("LW_STL", 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, 4'd3, C_MRD);
        step("LW_STL", 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, 4'd3, C_MRD);
        step("LW_RDY", 6'b100011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd3, C_MRD);
        step("LW_WB", 6'b100011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd4, C_MWB);
        retire_one();

        instr_beq("BEQ_T", 1'b1, C_BRT);
        instr_beq("BEQ_N", 1'b0, C_BRN);

        // Illegal opcode: flagged in DECODE only, not retired
        step("ILL_OP", 6'b111111, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, C_FR);
        step("ILL_OP", 6'b111111, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, C_DECI);
        // Illegal funct: flagged in EXEC only
        step("ILL_FN", 6'b000000, 6'b000111, 1'b0, 1'b1, 1'b0, 4'd0, C_FR);
        step("ILL_FN", 6'b000000, 6'b000111, 1'b0, 1'b1, 1'b0, 4'd1, C_DEC);
        step("ILL_FN", 6'b000000, 6'b000111, 1'b0, 1'b1, 1'b0, 4'd6, C_EXI);

        step("ADDI", 6'b001000, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, C_FR);
        step("ADDI", 6'b001000, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, C_DEC);
        step("ADDI", 6'b001000, 6'd0, 1'b0, 1'b1, 1'b0, 4'd9, C_MADR);
        step("ADDI", 6'b001000, 6'd0, 1'b0, 1'b1, 1'b0, 4'd10, C_AIWB);
        retire_one();

        // sw with a fetch stall, completes on first MEMWR cycle
        step("SW_FSTL", 6'b101011, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, C_FW);
        step("SW", 6'b101011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, C_FR);
        step("SW", 6'b101011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, C_DEC);
        step("SW", 6'b101011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd2, C_MADR);
        step("SW_WR", 6'b101011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd5, C_MWR);
        retire_one();

        // sw abandoned by reset while stalled in MEMWR
        step("SW2", 6'b101011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, C_FR);
        step("SW2", 6'b101011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, C_DEC);
        step("SW2", 6'b101011, 6'd0, 1'b0, 1'b1, 1'b0, 4'd2, C_MADR);
        step("SW2_STL", 6'b101011, 6'd0, 1'b0, 1'b0, 1'b0, 4'd5, C_MWR);
        step("SW2_RST", 6'b101011, 6'd0, 1'b0, 1'b0, 1'b1, 4'd0, C_FW);
        chk1 = 1'b1;
        step("RST2", 6'b000010, 6'd0, 1'b0, 1'b1, 1'b1, 4'd0, C_FW);

        // 16 jumps: the 4-bit counter wraps, the no-wait instance never stalls
        for (int i = 0; i < 16; i++) begin
            step("J", 6'b000010, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, C_FR);
            step("J", 6'b000010, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, C_DEC);
            step("J", 6'b000010, 6'd0, 1'b0, 1'b1, 1'b0, 4'd11, C_JMP);
            retire_one();
        end
        step("J_END", 6'b000000, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, C_FR);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
